// File: rtl/perf_pkg.sv
// perf_pkg: register offsets, CTRL/CFG bit positions and the per-channel
// configuration struct shared by the performance counter bank.
package perf_pkg;

  localparam logic [7:0] PERF_CTRL      = 8'h00;
  localparam logic [7:0] PERF_STATUS    = 8'h04;
  localparam logic [7:0] PERF_IRQMASK   = 8'h08;
  localparam logic [7:0] PERF_CFG_BASE  = 8'h40;
  localparam logic [7:0] PERF_SNAP_BASE = 8'h80;

  localparam int CTRL_GEN  = 0;
  localparam int CTRL_CLR  = 1;
  localparam int CTRL_SNAP = 2;

  localparam int CFG_EVSEL_LSB = 0;
  localparam int CFG_EN        = 8;
  localparam int CFG_NOSTALL   = 9;

  // evsel is sized for the largest event count (16); the top level masks
  // writes down to EVSEL_W bits so the unused upper bits always read 0.
  typedef struct packed {
    logic       nostall;
    logic       en;
    logic [3:0] evsel;
  } perf_cfg_t;

  function automatic logic [31:0] cfg_to_word(input perf_cfg_t c);
    logic [31:0] w;
    w = '0;
    w[CFG_EVSEL_LSB +: 4] = c.evsel;
    w[CFG_EN]             = c.en;
    w[CFG_NOSTALL]        = c.nostall;
    return w;
  endfunction

endpackage

// File: rtl/perf_counter_chan.sv
// perf_counter_chan: one live event counter plus its snapshot register.
// Handles event select, stall gating, wrap with overflow pulse, word
// preload, and the bank-wide CLR/SNAP strobes.
module perf_counter_chan
  import perf_pkg::*;
#(
  parameter int CTR_WIDTH = 32
) (
  input  logic                 CLK,
  input  logic                 reset_n,
  input  logic                 gen,
  input  perf_cfg_t            cfg,
  input  logic [15:0]          events,
  input  logic                 stall,
  input  logic                 clr,
  input  logic                 snap,
  input  logic                 wr_lo,
  input  logic                 wr_hi,
  input  logic [31:0]          wdata,
  output logic [CTR_WIDTH-1:0] snap_val,
  output logic                 ovf
);

  localparam bit HAS_HI = (CTR_WIDTH > 32);

  logic [CTR_WIDTH-1:0] live;
  logic [CTR_WIDTH-1:0] live_d;
  logic [63:0]          pre_ext;
  logic                 inc;
  logic                 preload;

  // events is zero-padded above NUM_EVENTS, so out-of-range selects count nothing
  assign inc     = gen & cfg.en & events[cfg.evsel] & (~cfg.nostall | ~stall);
  assign preload = wr_lo | (wr_hi & HAS_HI);
  assign ovf     = inc & ~clr & ~preload & (&live);

  // merge the written word into the current value for preload
  always_comb begin
    pre_ext = 64'(live);
    if (wr_lo) pre_ext[31:0]  = wdata;
    if (wr_hi) pre_ext[63:32] = wdata;
  end

  // next live value: CLR over preload over increment
  always_comb begin
    live_d = live;
    if (clr)          live_d = '0;
    else if (preload) live_d = pre_ext[CTR_WIDTH-1:0];
    else if (inc)     live_d = live + 1'b1;
  end

  // live counter and snapshot; snapshot takes the pre-edge (pre-clear) value
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      live     <= '0;
      snap_val <= '0;
    end else begin
      live <= live_d;
      if (snap) snap_val <= live;
    end
  end

  if (CTR_WIDTH < 64) begin : g_unused
    logic unused_pre_hi;
    assign unused_pre_hi = ^pre_ext[63:CTR_WIDTH];
  end

endmodule

// File: rtl/perf_counter_bank.sv
// perf_counter_bank: memory-mapped bank of NUM_CTRS event counters with
// global enable, atomic snapshot, clear and sticky W1C overflow status.
// Optional overflow interrupt and IRQMASK register with PERF_OVF_IRQ_EN.
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int NUM_CTRS   = 4,
  parameter int CTR_WIDTH  = 32,
  parameter int NUM_EVENTS = 8
) (
  input  logic                  CLK,
  input  logic                  reset_n,
  input  logic [NUM_EVENTS-1:0] events,
  input  logic                  Stall,
  input  logic [7:0]            addr,
  input  logic                  rd_en,
  input  logic                  wr_en,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata,
  output logic                  rvalid
`ifdef PERF_OVF_IRQ_EN
  ,
  output logic                  ovf_irq
`endif
);

  localparam int         EVSEL_W    = $clog2(NUM_EVENTS);
  localparam logic [3:0] EVSEL_MASK = 4'((1 << EVSEL_W) - 1);

  logic                 gen_q;
  logic [NUM_CTRS-1:0]  status_q;
  logic [NUM_CTRS-1:0]  status_clr;
  logic [NUM_CTRS-1:0]  ovf_vec;
  logic [NUM_CTRS-1:0]  wr_lo_vec;
  logic [NUM_CTRS-1:0]  wr_hi_vec;
  perf_cfg_t            cfg_q    [NUM_CTRS];
  logic [CTR_WIDTH-1:0] snap_vec [NUM_CTRS];
  logic [15:0]          ev_ext;
  logic [2:0]           cfg_idx;
  logic [2:0]           snap_idx;
  logic                 hit_ctrl, hit_status, hit_cfg, hit_snap;
  logic                 do_clr, do_snap;
  logic [31:0]          rd_mux;
  logic [63:0]          snap_word;
  logic                 unused_addr;

  assign ev_ext      = 16'(events);
  assign cfg_idx     = addr[4:2];
  assign snap_idx    = addr[5:3];
  assign hit_ctrl    = (addr[7:2] == PERF_CTRL[7:2]);
  assign hit_status  = (addr[7:2] == PERF_STATUS[7:2]);
  assign hit_cfg     = (addr[7:5] == PERF_CFG_BASE[7:5]) && (int'(cfg_idx) < NUM_CTRS);
  assign hit_snap    = (addr[7:6] == PERF_SNAP_BASE[7:6]) && (int'(snap_idx) < NUM_CTRS);
  assign do_clr      = wr_en & hit_ctrl & wdata[CTRL_CLR];
  assign do_snap     = wr_en & hit_ctrl & wdata[CTRL_SNAP];
  assign status_clr  = (wr_en && hit_status) ? wdata[NUM_CTRS-1:0] : '0;
  assign unused_addr = ^addr[1:0];

  for (genvar g = 0; g < NUM_CTRS; g++) begin : g_chan
    assign wr_lo_vec[g] = wr_en & hit_snap & ~addr[2] & (int'(snap_idx) == g);
    assign wr_hi_vec[g] = wr_en & hit_snap &  addr[2] & (int'(snap_idx) == g);

    perf_counter_chan #(.CTR_WIDTH(CTR_WIDTH)) u_chan (
      .CLK      (CLK),
      .reset_n  (reset_n),
      .gen      (gen_q),
      .cfg      (cfg_q[g]),
      .events   (ev_ext),
      .stall    (Stall),
      .clr      (do_clr),
      .snap     (do_snap),
      .wr_lo    (wr_lo_vec[g]),
      .wr_hi    (wr_hi_vec[g]),
      .wdata    (wdata),
      .snap_val (snap_vec[g]),
      .ovf      (ovf_vec[g])
    );
  end

  // CTRL, sticky STATUS (a same-edge overflow beats W1C) and CFG registers
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      gen_q    <= 1'b0;
      status_q <= '0;
      for (int i = 0; i < NUM_CTRS; i++) cfg_q[i] <= '0;
    end else begin
      if (wr_en && hit_ctrl) gen_q <= wdata[CTRL_GEN];
      status_q <= (status_q & ~status_clr) | ovf_vec;
      for (int i = 0; i < NUM_CTRS; i++) begin
        if (wr_en && hit_cfg && (int'(cfg_idx) == i)) begin
          cfg_q[i].evsel   <= wdata[CFG_EVSEL_LSB +: 4] & EVSEL_MASK;
          cfg_q[i].en      <= wdata[CFG_EN];
          cfg_q[i].nostall <= wdata[CFG_NOSTALL];
        end
      end
    end
  end

`ifdef PERF_OVF_IRQ_EN
  logic                hit_irqmask;
  logic [NUM_CTRS-1:0] irqmask_q;

  assign hit_irqmask = (addr[7:2] == PERF_IRQMASK[7:2]);

  // interrupt mask and registered interrupt, one cycle behind STATUS
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      irqmask_q <= '0;
      ovf_irq   <= 1'b0;
    end else begin
      if (wr_en && hit_irqmask) irqmask_q <= wdata[NUM_CTRS-1:0];
      ovf_irq <= |(status_q & irqmask_q);
    end
  end
`endif

  // read mux over current register state, so a same-cycle write is not visible
  always_comb begin
    rd_mux    = '0;
    snap_word = '0;
    if (hit_ctrl) begin
      rd_mux[CTRL_GEN] = gen_q;
    end else if (hit_status) begin
      rd_mux[NUM_CTRS-1:0] = status_q;
`ifdef PERF_OVF_IRQ_EN
    end else if (hit_irqmask) begin
      rd_mux[NUM_CTRS-1:0] = irqmask_q;
`endif
    end else if (hit_cfg) begin
      for (int i = 0; i < NUM_CTRS; i++)
        if (int'(cfg_idx) == i) rd_mux = cfg_to_word(cfg_q[i]);
    end else if (hit_snap) begin
      for (int i = 0; i < NUM_CTRS; i++)
        if (int'(snap_idx) == i) snap_word = 64'(snap_vec[i]);
      rd_mux = addr[2] ? snap_word[63:32] : snap_word[31:0];
    end
  end

  // one-cycle read response; rdata holds between reads
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= rd_en;
      if (rd_en) rdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Testbench for perf_counter_bank: per-scenario tasks driving the register
// port; expected read data is queued at issue and compared when rvalid fires.
module tb_perf_counter_bank;

  logic        CLK;
  logic        reset_n;
  logic [7:0]  events;
  logic        Stall;
  logic [7:0]  addr;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rvalid;
`ifdef PERF_OVF_IRQ_EN
  logic        ovf_irq;
`endif

  int          errors = 0;
  int          checks = 0;
  logic [31:0] sb[$];
  logic [31:0] exp_q;

  perf_counter_bank dut (
    .CLK     (CLK),
    .reset_n (reset_n),
    .events  (events),
    .Stall   (Stall),
    .addr    (addr),
    .rd_en   (rd_en),
    .wr_en   (wr_en),
    .wdata   (wdata),
    .rdata   (rdata),
    .rvalid  (rvalid)
`ifdef PERF_OVF_IRQ_EN
    ,
    .ovf_irq (ovf_irq)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // scoreboard: every rvalid pops one expected word
  always @(negedge CLK) begin
    if (rvalid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: rvalid with rdata=%h, no read outstanding", rdata);
      end else begin
        exp_q = sb.pop_front();
        if (rdata !== exp_q) begin
          errors++;
          $display("FAIL rd_data addr=%h: got %h expected %h", addr, rdata, exp_q);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    addr = a; wdata = d; wr_en = 1'b1;
    @(negedge CLK);
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] e);
    addr = a; rd_en = 1'b1;
    sb.push_back(e);
    @(negedge CLK);
    rd_en = 1'b0;
  endtask

  task automatic test_reset;
    checks++;
    if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
    checks++;
    if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b expected 0", rvalid); end
`ifdef PERF_OVF_IRQ_EN
    checks++;
    if (ovf_irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", ovf_irq); end
`endif
    reset_n = 1'b1;
    @(negedge CLK);
    rd(8'h00, 32'h0);
    rd(8'h04, 32'h0);
    rd(8'h40, 32'h0);
    rd(8'h80, 32'h0);
    rd(8'h08, 32'h0);
  endtask

  task automatic test_cycles;
    wr(8'h40, 32'h100);
    wr(8'h00, 32'h3);
    cyc(100);
    wr(8'h00, 32'h5);
    addr = 8'h80; rd_en = 1'b1;
    sb.push_back(32'd100);
    @(negedge CLK);
    rd_en = 1'b0;
    checks++;
    if (rvalid !== 1'b1) begin errors++; $display("FAIL rvalid_latency: got %b expected 1", rvalid); end
    @(negedge CLK);
    checks++;
    if (rvalid !== 1'b0) begin errors++; $display("FAIL rvalid_pulse: got %b expected 0", rvalid); end
    checks++;
    if (rdata !== 32'd100) begin errors++; $display("FAIL rdata_hold: got %h expected %h", rdata, 32'd100); end
  endtask

  task automatic test_preload;
    wr(8'h80, 32'h50);
    wr(8'h00, 32'h5);
    rd(8'h80, 32'h50);
  endtask

  task automatic test_overflow;
    wr(8'h44, 32'h103);
    rd(8'h44, 32'h103);
    wr(8'h88, 32'hFFFF_FFFE);
    for (int k = 0; k < 3; k++) begin
      events[3] = 1'b1;
      @(negedge CLK);
      events[3] = 1'b0;
      @(negedge CLK);
    end
    wr(8'h00, 32'h5);
    rd(8'h88, 32'h1);
    rd(8'h8C, 32'h0);
    rd(8'h04, 32'h2);
    wr(8'h04, 32'h2);
    rd(8'h04, 32'h0);
  endtask

  task automatic test_set_beats_w1c;
    wr(8'h88, 32'hFFFF_FFFF);
    events[3] = 1'b1;
    wr(8'h04, 32'h2);
    events[3] = 1'b0;
    rd(8'h04, 32'h2);
    wr(8'h04, 32'h2);
    rd(8'h04, 32'h0);
  endtask

  task automatic test_nostall;
    wr(8'h48, 32'h302);
    rd(8'h48, 32'h302);
    for (int i = 0; i < 40; i++) begin
      events[2] = 1'b1;
      Stall = i[0];
      @(negedge CLK);
    end
    events[2] = 1'b0;
    Stall = 1'b0;
    wr(8'h00, 32'h5);
    rd(8'h90, 32'd20);
  endtask

  task automatic test_clr_snap;
    wr(8'h4C, 32'h104);
    for (int i = 0; i < 10; i++) begin
      events[4] = 1'b1;
      @(negedge CLK);
    end
    events[4] = 1'b0;
    wr(8'h00, 32'h7);
    rd(8'h98, 32'd10);
    rd(8'h00, 32'h1);
    for (int i = 0; i < 5; i++) begin
      events[4] = 1'b1;
      @(negedge CLK);
    end
    events[4] = 1'b0;
    wr(8'h00, 32'h5);
    rd(8'h98, 32'd5);
  endtask

  task automatic test_back_to_back;
    addr = 8'h4C; wdata = 32'h105; wr_en = 1'b1; rd_en = 1'b1;
    sb.push_back(32'h104);
    @(negedge CLK);
    wr_en = 1'b0; rd_en = 1'b0;
    rd(8'h4C, 32'h105);
    rd(8'h44, 32'h103);
  endtask

  task automatic test_unmapped;
    wr(8'h30, 32'hFFFF_FFFF);
    wr(8'hA0, 32'h1234_5678);
    rd(8'h30, 32'h0);
    rd(8'h50, 32'h0);
    rd(8'hA0, 32'h0);
    rd(8'hC0, 32'h0);
`ifndef PERF_OVF_IRQ_EN
    wr(8'h08, 32'h1);
    rd(8'h08, 32'h0);
`endif
  endtask

`ifdef PERF_OVF_IRQ_EN
  task automatic test_irq;
    wr(8'h08, 32'h1);
    rd(8'h08, 32'h1);
    wr(8'h80, 32'hFFFF_FFFE);
    checks++;
    if (ovf_irq !== 1'b0) begin errors++; $display("FAIL irq_pre0: got %b expected 0", ovf_irq); end
    @(negedge CLK);
    checks++;
    if (ovf_irq !== 1'b0) begin errors++; $display("FAIL irq_pre1: got %b expected 0", ovf_irq); end
    @(negedge CLK);
    checks++;
    if (ovf_irq !== 1'b0) begin errors++; $display("FAIL irq_wrap_edge: got %b expected 0", ovf_irq); end
    @(negedge CLK);
    checks++;
    if (ovf_irq !== 1'b1) begin errors++; $display("FAIL irq_rise: got %b expected 1", ovf_irq); end
    wr(8'h04, 32'h1);
    checks++;
    if (ovf_irq !== 1'b1) begin errors++; $display("FAIL irq_hold: got %b expected 1", ovf_irq); end
    @(negedge CLK);
    checks++;
    if (ovf_irq !== 1'b0) begin errors++; $display("FAIL irq_fall: got %b expected 0", ovf_irq); end
    rd(8'h04, 32'h0);
  endtask
`endif

  task automatic test_reset_mid_read;
    rd(8'h40, 32'h100);
    addr = 8'h40; rd_en = 1'b1;
    @(posedge CLK);
    #1;
    reset_n = 1'b0;
    rd_en = 1'b0;
    #1;
    checks++;
    if (rvalid !== 1'b0) begin errors++; $display("FAIL midrd_rvalid: got %b expected 0", rvalid); end
    checks++;
    if (rdata !== 32'h0) begin errors++; $display("FAIL midrd_rdata: got %h expected 0", rdata); end
`ifdef PERF_OVF_IRQ_EN
    checks++;
    if (ovf_irq !== 1'b0) begin errors++; $display("FAIL midrd_irq: got %b expected 0", ovf_irq); end
`endif
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checks++;
      if (rvalid !== 1'b0) begin errors++; $display("FAIL midrd_no_rvalid: got %b expected 0", rvalid); end
    end
    reset_n = 1'b1;
    @(negedge CLK);
    rd(8'h00, 32'h0);
    rd(8'h40, 32'h0);
    rd(8'h80, 32'h0);
    rd(8'h04, 32'h0);
  endtask

  initial begin
    reset_n = 1'b1;
    events  = 8'h01;
    Stall   = 1'b0;
    addr    = 8'h00;
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    wdata   = 32'h0;
    #1;
    reset_n = 1'b0;
    repeat (3) @(negedge CLK);
    test_reset;
    test_cycles;
    test_preload;
    test_overflow;
    test_set_beats_w1c;
    test_nostall;
    test_clr_snap;
    test_back_to_back;
    test_unmapped;
`ifdef PERF_OVF_IRQ_EN
    test_irq;
`endif
    test_reset_mid_read;
    cyc(2);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d reads outstanding expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
